// File: rtl/cvita_sid_stamp.sv
// rtl/cvita_sid_stamp.sv - stamps a table-selected destination SID into CVITA headers
// Packets whose table entry is invalid are discarded whole and counted.
module cvita_sid_stamp #(
   parameter int DEST_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_stb,
   input  logic [7:0]            set_addr,
   input  logic [31:0]           set_data,
   input  logic [63:0]           i_tdata,
   input  logic                  i_tlast,
   input  logic                  i_tvalid,
   output logic                  i_tready,
   input  logic [DEST_WIDTH-1:0] i_tdest,
   output logic [63:0]           o_tdata,
   output logic                  o_tlast,
   output logic                  o_tvalid,
   input  logic                  o_tready,
   output logic [DEST_WIDTH-1:0] o_tdest,
   output logic [31:0]           drop_count
);

   localparam int N = 1 << DEST_WIDTH;

   typedef enum logic [1:0] {HEAD, BODY, DROP} state_t;

   state_t                state_q, state_d;
   logic [15:0]           sid_q [N];
   logic [N-1:0]          vld_q;
   logic [63:0]           tdata_q, tdata_d;
   logic                  tlast_q, tlast_d;
   logic                  tvalid_q, tvalid_d;
   logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
   logic [31:0]           drop_q, drop_d;

   logic        tbl_we, cnt_clr, drop_inc, ready, out_free, entry_vld;
   logic [15:0] entry_sid;
   logic        unused_set_bits;

   assign unused_set_bits = ^set_data[31:17];
   assign tbl_we  = set_stb && (set_addr < 8'(N));
   assign cnt_clr = set_stb && (set_addr == 8'hFF) && set_data[0];

   // Lookups read the registered table, so a same-cycle write is seen only by later headers.
   assign entry_vld = vld_q[i_tdest];
   assign entry_sid = sid_q[i_tdest];
   assign out_free  = o_tready || !tvalid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < N; i++) sid_q[i] <= '0;
      end else if (tbl_we) begin
         sid_q[set_addr[DEST_WIDTH-1:0]] <= set_data[15:0];
         vld_q[set_addr[DEST_WIDTH-1:0]] <= set_data[16];
      end
   end

   always_comb begin
      state_d  = state_q;
      tdata_d  = tdata_q;
      tlast_d  = tlast_q;
      tdest_d  = tdest_q;
      tvalid_d = tvalid_q && !o_tready;
      ready    = 1'b0;
      drop_inc = 1'b0;
      case (state_q)
         HEAD: begin
            ready = entry_vld ? out_free : 1'b1;
            if (i_tvalid && ready) begin
               if (entry_vld) begin
                  tvalid_d = 1'b1;
                  tdata_d  = {i_tdata[63:16], entry_sid};
                  tlast_d  = i_tlast;
                  tdest_d  = i_tdest;
                  state_d  = i_tlast ? HEAD : BODY;
               end else begin
                  drop_inc = 1'b1;
                  state_d  = i_tlast ? HEAD : DROP;
               end
            end
         end
         BODY: begin
            ready = out_free;
            if (i_tvalid && ready) begin
               tvalid_d = 1'b1;
               tdata_d  = i_tdata;
               tlast_d  = i_tlast;
               if (i_tlast) state_d = HEAD;
            end
         end
         DROP: begin
            ready = 1'b1;
            if (i_tvalid && i_tlast) state_d = HEAD;
         end
         default: state_d = HEAD;
      endcase
      // Clear beats a same-cycle increment.
      drop_d = cnt_clr ? 32'd0 : (drop_inc ? drop_q + 32'd1 : drop_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= HEAD;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         tvalid_q <= 1'b0;
         tdest_q  <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         tdata_q  <= tdata_d;
         tlast_q  <= tlast_d;
         tvalid_q <= tvalid_d;
         tdest_q  <= tdest_d;
         drop_q   <= drop_d;
      end
   end

   assign i_tready   = ready && rst_n;
   assign o_tdata    = tdata_q;
   assign o_tlast    = tlast_q;
   assign o_tvalid   = tvalid_q;
   assign o_tdest    = tdest_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_cvita_sid_stamp.sv
// tb/tb_cvita_sid_stamp.sv - directed self-checking bench for cvita_sid_stamp
module tb_cvita_sid_stamp;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          set_stb;
   logic [7:0]    set_addr;
   logic [31:0]   set_data;
   logic [63:0]   i_tdata;
   logic          i_tlast;
   logic          i_tvalid;
   logic          i_tready;
   logic [DW-1:0] i_tdest;
   logic [63:0]   o_tdata;
   logic          o_tlast;
   logic          o_tvalid;
   logic          o_tready;
   logic [DW-1:0] o_tdest;
   logic [31:0]   drop_count;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cvita_sid_stamp #(.DEST_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tdest(i_tdest),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdest(o_tdest),
      .drop_count(drop_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic [DW-1:0] dest, input logic last);
      i_tvalid = v;
      i_tdata  = d;
      i_tdest  = dest;
      i_tlast  = last;
      #1;
   endtask

   task automatic setw(input logic [7:0] a, input logic [31:0] d);
      set_stb  = 1'b1;
      set_addr = a;
      set_data = d;
      tick();
      set_stb  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
      i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; i_tdest = '0; o_tready = 1'b1;
      #12;
      check("rst_i_tready", i_tready, 0);
      check("rst_o_tvalid", o_tvalid, 0);
      check("rst_o_tdata", o_tdata, 0);
      check("rst_drop_count", drop_count, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Stamp; the alias address 0x13 must not touch entry 3
      setw(8'h03, 32'h0001_0A21);
      setw(8'h13, 32'h0001_1234);
      drive(1, 64'h1111_2222_3333_4444, 3, 0);
      check("stamp_ready", i_tready, 1);
      tick();
      check("stamp_hdr", o_tdata, 64'h1111_2222_3333_0A21);
      check("stamp_valid", o_tvalid, 1);
      check("stamp_tdest", o_tdest, 3);
      check("stamp_hdr_last", o_tlast, 0);
      for (int k = 1; k <= 3; k++) begin
         drive(1, 64'hB0B0_0000_0000_0000 | 64'(k), 5, k == 3);
         tick();
         check("stamp_body", o_tdata, 64'hB0B0_0000_0000_0000 | 64'(k));
         check("stamp_body_last", o_tlast, k == 3);
         check("stamp_body_tdest", o_tdest, 3);
      end
      drive(0, 0, 0, 0);
      tick();
      check("stamp_idle", o_tvalid, 0);

      // Drop a 3-beat packet, then stamp the next one with no bubble
      drive(1, 64'hD0, 5, 0);
      check("drop_ready", i_tready, 1);
      tick();
      check("drop_b0_novalid", o_tvalid, 0);
      drive(1, 64'hD1, 3, 0);
      tick();
      drive(1, 64'hD2, 3, 1);
      tick();
      check("drop_b2_novalid", o_tvalid, 0);
      check("drop_count1", drop_count, 1);
      drive(1, 64'hAAAA_BBBB_CCCC_DDDD, 3, 0);
      tick();
      check("after_drop_hdr", o_tdata, 64'hAAAA_BBBB_CCCC_0A21);
      check("after_drop_valid", o_tvalid, 1);
      drive(1, 64'h5555, 3, 1);
      tick();
      check("after_drop_b1", o_tdata, 64'h5555);
      check("after_drop_last", o_tlast, 1);
      drive(0, 0, 0, 0);
      tick();

      // Backpressure in BODY
      drive(1, 64'hC0DE_0000_0000_0000, 3, 0);
      tick();
      drive(1, 64'hC1, 3, 0);
      tick();
      o_tready = 1'b0;
      drive(1, 64'hC2, 3, 0);
      for (int k = 0; k < 5; k++) begin
         check("bp_ready_low", i_tready, 0);
         tick();
         check("bp_hold_data", o_tdata, 64'hC1);
         check("bp_hold_valid", o_tvalid, 1);
      end
      o_tready = 1'b1;
      #1;
      check("bp_release_ready", i_tready, 1);
      tick();
      check("bp_c2", o_tdata, 64'hC2);
      check("bp_c2_last", o_tlast, 0);
      drive(1, 64'hC3, 3, 1);
      tick();
      check("bp_c3", o_tdata, 64'hC3);
      check("bp_c3_last", o_tlast, 1);
      drive(0, 0, 0, 0);
      tick();
      check("bp_idle", o_tvalid, 0);

      // Back-to-back single-beat packets with a same-cycle table write
      drive(1, 64'h5100_0000_0000_FFFF, 3, 1);
      tick();
      check("sb0_data", o_tdata, 64'h5100_0000_0000_0A21);
      check("sb0_valid", o_tvalid, 1);
      drive(1, 64'h5101_0000_0000_FFFF, 3, 1);
      setw(8'h03, 32'h0001_0B00);
      check("sb1_data_old_sid", o_tdata, 64'h5101_0000_0000_0A21);
      check("sb1_valid", o_tvalid, 1);
      drive(1, 64'h5102_0000_0000_FFFF, 3, 1);
      tick();
      check("sb2_data_new_sid", o_tdata, 64'h5102_0000_0000_0B00);
      check("sb2_valid", o_tvalid, 1);
      drive(0, 0, 0, 0);
      tick();

      // Counter clear wins over a same-cycle drop
      drive(1, 64'hE0, 5, 1);
      tick();
      drive(1, 64'hE1, 5, 1);
      tick();
      check("cnt_before_clear", drop_count, 3);
      drive(1, 64'hE2, 5, 1);
      setw(8'hFF, 32'h0000_0001);
      check("cnt_clear_wins", drop_count, 0);

      // Drop proceeds while the output is stalled
      drive(1, 64'hF000_0000_0000_0000, 3, 1);
      tick();
      o_tready = 1'b0;
      drive(1, 64'hE3, 5, 1);
      check("stall_drop_ready", i_tready, 1);
      tick();
      check("stall_drop_count", drop_count, 1);
      check("stall_hold_data", o_tdata, 64'hF000_0000_0000_0B00);
      check("stall_hold_valid", o_tvalid, 1);
      drive(0, 0, 0, 0);
      setw(8'hFF, 32'h0000_0002);
      check("no_clear_bit0_low", drop_count, 1);
      o_tready = 1'b1;
      tick();

      // Asynchronous reset mid-packet
      drive(1, 64'h7700_0000_0000_0000, 3, 0);
      tick();
      check("pre_rst_valid", o_tvalid, 1);
      drive(1, 64'h7701, 3, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", o_tvalid, 0);
      check("async_rst_count", drop_count, 0);
      check("async_rst_ready", i_tready, 0);
      check("async_rst_data", o_tdata, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1, 64'h99, 3, 1);
      check("post_rst_ready", i_tready, 1);
      tick();
      check("post_rst_no_out", o_tvalid, 0);
      check("post_rst_dropped", drop_count, 1);
      drive(0, 0, 0, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cvita_sid_stamp.md
# cvita_sid_stamp

Transmit-side counterpart to the CVITA destination lookup: takes a CVITA stream whose destination is given as a sideband port index (`i_tdest`) and writes the matching destination SID into the header. The SID comes from a settings-bus-programmed table. Sits in front of the crossbar egress, or at a block's output port, so that upstream logic only selects a port and never builds SIDs. Packets whose table entry is not valid are dropped whole and counted.

## Interface
- `DEST_WIDTH`, 4 — width of `i_tdest`/`o_tdest`. Legal range is 1–7. The table has 2^DEST_WIDTH entries.
- `clk` input 1 — single clock for all logic.
- `rst_n` input 1 — asynchronous, active-low reset.
- `set_stb` input 1 — settings write strobe.
- `set_addr` input 8 — settings address.
- `set_data` input 32 — settings data.
- `i_tdata` input 64 — CVITA input data. Beat 0 of each packet is the header.
- `i_tlast` input 1 — last beat of the input packet.
- `i_tvalid` input 1 — input valid.
- `i_tready` output 1 — input ready.
- `i_tdest` input DEST_WIDTH — table index. Sampled only on the header beat.
- `o_tdata` output 64 — stamped output data.
- `o_tlast` output 1 — last beat of the output packet.
- `o_tvalid` output 1 — output valid.
- `o_tready` input 1 — output ready.
- `o_tdest` output DEST_WIDTH — `i_tdest` latched at the header beat. Held for the whole packet.
- `drop_count` output 32 — number of packets dropped. Wraps at 2^32.

## Operation
- **Table write.**
  - `set_stb` with `set_addr < 2^DEST_WIDTH` writes entry `set_addr`.
  - SID = `set_data[15:0]`; valid = `set_data[16]`.
- **Counter clear.** `set_stb` with `set_addr == 8'hFF` and `set_data[0] == 1` clears `drop_count`.
- **Other addresses.** All other addresses are ignored.
- **Table reads.** Combinational from the current register contents.
  - A write in the same cycle as a header lookup is not seen by that lookup; the old value is used.
- **State machine.** States HEAD, BODY, DROP. Reset state is HEAD.
- **HEAD, input beat accepted (`i_tvalid && i_tready`):**
  - **Entry `i_tdest` valid:**
    - Forward the beat with `o_tdata[63:16] = i_tdata[63:16]` and `o_tdata[15:0] = entry SID`.
    - Latch `o_tdest = i_tdest`.
    - Next state: BODY if `!i_tlast`, else stay in HEAD.
  - **Entry `i_tdest` invalid:**
    - Discard the beat and increment `drop_count`.
    - Next state: DROP if `!i_tlast`, else stay in HEAD.
- **BODY.** Forward beats unmodified. Return to HEAD on an accepted beat with `i_tlast`.
- **DROP.** Accept and discard every beat (`i_tready = 1`). Return to HEAD on an accepted beat with `i_tlast`.
- **Counter clear vs. increment.** If a clear and an increment land in the same cycle, the clear wins and the result is 0.
- **Output register.** A single registered output stage holds `o_tdata`, `o_tlast`, `o_tvalid`, `o_tdest`.
  - In HEAD (valid entry) and BODY: `i_tready = o_tready || !o_tvalid`.
  - Discarded beats never load the output register.

## Timing
- **Reset values** (asserted asynchronously):
  - `o_tvalid = 0`, `o_tlast = 0`, `o_tdata = 0`, `o_tdest = 0`, `drop_count = 0`.
  - All table entries: valid = 0, SID = 0.
  - State = HEAD.
  - `i_tready = 0` while `rst_n` is low.
- **Latency.** 1 cycle: a beat accepted in cycle N appears on the output in cycle N+1.
- **Throughput.** Full rate, 1 beat/cycle, while `o_tready` stays high.
- **Output hold.** When `o_tvalid && !o_tready`, the output register holds its contents.
  - `i_tready` is then low in HEAD (valid-entry path) and BODY.
- **Drop path.** Discard occurs even while the output is stalled: in DROP, and in HEAD with an invalid entry, `i_tready` is 1 regardless of `o_tready`.
- **Single-beat packet** (`i_tlast` on the header beat): stamped or dropped, and the state stays in HEAD.
- **Back-to-back packets.** The header beat that immediately follows a `tlast` beat is looked up with no bubble.
- **`i_tdest` outside the header beat** is ignored.
- **Reset mid-packet.** The output is flushed and state returns to HEAD; the next accepted beat is treated as a header. Realigning after a reset is the upstream's responsibility.
- **Table write mid-packet.** Does not affect the packet in flight; the SID was captured at the header beat.

## Test plan
- **Stamp:** write entry 3 with SID `0x0A21`, valid bit set. Send a 4-beat packet, header `0x1111_2222_3333_4444`, `i_tdest = 3`, `o_tready = 1`.
  - Expect header out `0x1111_2222_3333_0A21` one cycle after input, `o_tdest = 3`.
  - Beats 1–3 unmodified; `o_tlast` on beat 3 only.
- **Drop:** entry 5 left invalid. Send a 3-beat packet with `i_tdest = 5`, then a 2-beat packet with `i_tdest = 3`.
  - Expect no output beats for the first packet and `drop_count = 1`.
  - Second packet stamped with `0x0A21`.
- **Backpressure:** hold `o_tready = 0` for 5 cycles in the middle of a BODY.
  - Expect the output stable, `i_tready = 0`, no beats lost or duplicated.
  - Output sequence matches input after release.
- **Single-beat packets and same-cycle write:** send single-beat packets back-to-back with `i_tdest` 3, 3, 3. On the second header cycle, write entry 3 = `0x0B00`.
  - Expect SIDs `0x0A21`, `0x0A21`, `0x0B00`, with no idle cycles in between.
- **Counter clear priority:** after 2 drops, write `0xFF` with `set_data[0] = 1` in the same cycle as a third drop's header.
  - Expect `drop_count = 0` afterwards.
  - A further drop gives `drop_count = 1`.
- **Asynchronous reset:** assert `rst_n = 0` mid-packet, between clock edges.
  - Expect `o_tvalid = 0` and `drop_count = 0` immediately, and the table invalid.
  - A post-reset packet to entry 3 is dropped.
